// File: rtl/bsg_fpu_pkg.sv
// Shared definitions for the FPU decoder slice.
//   fpu_class_s     : per-lane classification flags carried through the pipe
//   ext_exp_width() : width of the extended (sign-capable) biased exponent
package bsg_fpu_pkg;

    typedef struct packed {
        logic zero;
        logic nan;
        logic sig_nan;
        logic infty;
        logic denormal;
    } fpu_class_s;

    // One extra bit so that a denormal's negative normalized exponent fits.
    function automatic int unsigned ext_exp_width(input int unsigned e);
        return e + 1;
    endfunction

endpackage

// File: rtl/bsg_fpu_clz.sv
// Leading-zero counter for a mantissa field.
//   data_i  : value to scan, MSB first
//   count_o : number of leading zeros; equals width_p when data_i is zero
module bsg_fpu_clz #(
    parameter int unsigned width_p = 23
) (
    input  logic [width_p-1:0]         data_i,
    output logic [$clog2(width_p+1)-1:0] count_o
);

    localparam int unsigned cnt_w = $clog2(width_p + 1);

    logic found;

    always_comb begin
        count_o = cnt_w'(width_p);
        found   = 1'b0;
        for (int unsigned i = 0; i < width_p; i++) begin
            if (!found && data_i[width_p-1-i]) begin
                count_o = cnt_w'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_fpu_decoder_pipe.sv
// Two-stage IEEE-754 operand decoder with valid/ready handshake.
// Stage 1 registers sign/exponent/mantissa, class flags and mantissa
// leading-zero count; stage 2 registers the normalized exponent/mantissa.
// Ports:
//   clk_i, reset_n_i (async active-low)
//   v_i/ready_o, a_i (els_p packed operands, lane 0 in LSBs), tag_i
//   v_o/ready_i, tag_o, per-lane flags zero_o nan_o sig_nan_o infty_o
//   denormal_o sign_o, exp_o (els_p x (e_p+1)), man_o (els_p x (m_p+1))
// Optional feature macro: BSG_FPU_DECODER_DAZ_EN adds daz_i
// (denormals-are-zero, sampled with v_i and carried with the transaction).
module bsg_fpu_decoder_pipe
    import bsg_fpu_pkg::*;
#(
    parameter int unsigned e_p         = 8,
    parameter int unsigned m_p         = 23,
    parameter int unsigned els_p       = 1,
    parameter int unsigned tag_width_p = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [els_p*(e_p+m_p+1)-1:0]   a_i,
    input  logic [tag_width_p-1:0]         tag_i,
`ifdef BSG_FPU_DECODER_DAZ_EN
    input  logic                           daz_i,
`endif
    output logic                           v_o,
    input  logic                           ready_i,
    output logic [tag_width_p-1:0]         tag_o,
    output logic [els_p-1:0]               zero_o,
    output logic [els_p-1:0]               nan_o,
    output logic [els_p-1:0]               sig_nan_o,
    output logic [els_p-1:0]               infty_o,
    output logic [els_p-1:0]               denormal_o,
    output logic [els_p-1:0]               sign_o,
    output logic [els_p*(e_p+1)-1:0]       exp_o,
    output logic [els_p*(m_p+1)-1:0]       man_o
);

    localparam int unsigned word_w = e_p + m_p + 1;
    localparam int unsigned ew     = ext_exp_width(e_p);
    localparam int unsigned lzw    = $clog2(m_p + 1);

    logic s1_v, s2_v;
    logic s1_load, s2_load;
    logic [tag_width_p-1:0] s1_tag, s2_tag;

    // A stage loads when empty or when the stage after it is taking data.
    assign s2_load = ~s2_v | ready_i;
    assign s1_load = ~s1_v | s2_load;
    assign ready_o = s1_load;
    assign v_o     = s2_v;
    assign tag_o   = s2_tag;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_load) s1_v <= v_i;
            if (s2_load) s2_v <= s1_v;
        end
    end

    always_ff @(posedge clk_i) begin
        if (s1_load) s1_tag <= tag_i;
        if (s2_load) s2_tag <= s1_tag;
    end

`ifdef BSG_FPU_DECODER_DAZ_EN
    logic s1_daz;
    always_ff @(posedge clk_i) begin
        if (s1_load) s1_daz <= daz_i;
    end
`endif

    for (genvar l = 0; l < els_p; l++) begin : lane
        logic             sign_f;
        logic [e_p-1:0]   exp_f;
        logic [m_p-1:0]   man_f;
        fpu_class_s       cls;
        logic [lzw-1:0]   lz;

        logic             s1_sign;
        logic [e_p-1:0]   s1_exp;
        logic [m_p-1:0]   s1_man;
        fpu_class_s       s1_cls;
        logic [lzw-1:0]   s1_lz;

        fpu_class_s       cls2;
        logic [ew-1:0]    norm_exp;
        logic [m_p:0]     norm_man;

        logic             s2_sign;
        fpu_class_s       s2_cls;
        logic [ew-1:0]    s2_exp;
        logic [m_p:0]     s2_man;

        assign {sign_f, exp_f, man_f} = a_i[l*word_w +: word_w];

        always_comb begin
            cls          = '0;
            cls.zero     = (exp_f == '0) && (man_f == '0);
            cls.denormal = (exp_f == '0) && (man_f != '0);
            cls.infty    = (exp_f == '1) && (man_f == '0);
            cls.nan      = (exp_f == '1) && (man_f != '0);
            cls.sig_nan  = cls.nan && !man_f[m_p-1];
        end

        bsg_fpu_clz #(.width_p(m_p)) clz (
            .data_i  (man_f),
            .count_o (lz)
        );

        always_ff @(posedge clk_i) begin
            if (s1_load) begin
                s1_sign <= sign_f;
                s1_exp  <= exp_f;
                s1_man  <= man_f;
                s1_cls  <= cls;
                s1_lz   <= lz;
            end
        end

        // Normalize shifter: denormals shift their first set bit into the
        // hidden-one position and take exponent -lz.
        always_comb begin
            cls2     = s1_cls;
            norm_exp = {1'b0, s1_exp};
            norm_man = {1'b1, s1_man};
            if (s1_cls.zero) begin
                norm_exp = '0;
            end else if (s1_cls.denormal) begin
                norm_exp = ew'(0) - ew'(s1_lz);
                norm_man = {m_p'(s1_man << s1_lz), 1'b0};
            end
`ifdef BSG_FPU_DECODER_DAZ_EN
            if (s1_daz && s1_cls.denormal) begin
                cls2.zero     = 1'b1;
                cls2.denormal = 1'b0;
                norm_exp      = '0;
                norm_man      = {1'b1, {m_p{1'b0}}};
            end
`endif
        end

        always_ff @(posedge clk_i) begin
            if (s2_load) begin
                s2_sign <= s1_sign;
                s2_cls  <= cls2;
                s2_exp  <= norm_exp;
                s2_man  <= norm_man;
            end
        end

        assign zero_o[l]              = s2_cls.zero;
        assign nan_o[l]               = s2_cls.nan;
        assign sig_nan_o[l]           = s2_cls.sig_nan;
        assign infty_o[l]             = s2_cls.infty;
        assign denormal_o[l]          = s2_cls.denormal;
        assign sign_o[l]              = s2_sign;
        assign exp_o[l*ew +: ew]      = s2_exp;
        assign man_o[l*(m_p+1) +: m_p+1] = s2_man;
    end

endmodule

// File: doc/bsg_fpu_decoder_pipe.md
BSG_FPU_DECODER_PIPE -- requirements
Module: bsg_fpu_decoder_pipe

Interface
REQ-001 The block SHALL have parameter e_p, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter m_p, default 23, meaning mantissa field width.
REQ-003 The block SHALL have parameter els_p, default 1, meaning number of parallel lanes sharing one handshake.
REQ-004 The block SHALL have parameter tag_width_p, default 4, meaning width of the opaque tag passed through with each transaction.
REQ-005 Port clk_i, input, 1 bit: the single clock; the block SHALL use no other clock.
REQ-006 Port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port v_i, input, 1 bit: input valid.
REQ-008 Port ready_o, output, 1 bit: input accepted when v_i & ready_o.
REQ-009 Port a_i, input, els_p*(e_p+m_p+1) bits: packed IEEE-754 operands, lane 0 in the LSBs.
REQ-010 Port tag_i, input, tag_width_p bits: transaction tag.
REQ-011 Port v_o, output, 1 bit: output valid.
REQ-012 Port ready_i, input, 1 bit: output consumed when v_o & ready_i.
REQ-013 Port tag_o, output, tag_width_p bits: tag of the current output.
REQ-014 Ports zero_o, nan_o, sig_nan_o, infty_o, denormal_o, sign_o, each output, els_p bits: per-lane classification flags.
REQ-015 Port exp_o, output, els_p*(e_p+1) bits: per-lane extended biased exponent, two's complement.
REQ-016 Port man_o, output, els_p*(m_p+1) bits: per-lane mantissa with explicit leading 1.

Function
REQ-017 The block SHALL be a two-stage pipeline with latency 2 cycles from acceptance to v_o, and SHALL sustain one transaction per cycle when ready_i is held at 1.
REQ-018 Stage 1 SHALL register, per lane, the sign, the exponent, the mantissa, the classification flags and the leading-zero count of the mantissa.
REQ-019 Stage 2 SHALL register, per lane, the normalized mantissa and exponent.
REQ-020 Classification SHALL follow these rules: zero = exp==0 & man==0; denormal = exp==0 & man!=0; infty = exp all-ones & man==0; nan = exp all-ones & man!=0; sig_nan = nan & man MSB==0.
REQ-021 For a normal or special lane, exp_o SHALL be {1'b0, exp} and man_o SHALL be {1'b1, man}.
REQ-022 For a denormal lane with leading-zero count lz, exp_o SHALL be -lz modulo 2^(e_p+1), and man_o SHALL be {man<<lz, 1'b0}.
REQ-023 For a zero lane, exp_o SHALL be 0 and man_o SHALL be {1'b1, man}.
REQ-024 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or when its downstream stage is accepting.
REQ-025 ready_o SHALL equal ~s1_v | ~s2_v | ready_i, and SHALL be purely combinational with no combinational path from v_i.
REQ-026 While v_o=1 and ready_i=0, all outputs SHALL remain stable.
REQ-027 A simultaneous accept and drain on a full pipe SHALL move data forward without losing or duplicating any transaction.
REQ-028 Tags SHALL emerge in the same order as they were accepted, each tag with its own data.

Reset
REQ-029 While reset_n_i=0, both stage valid bits SHALL be 0, so v_o=0, and ready_o SHALL be 1.
REQ-030 Data registers SHALL not be reset; outputs other than v_o are don't-care while v_o=0.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight transactions immediately (asynchronously).
REQ-032 Reset deassertion SHALL be used synchronously; the first accept SHALL occur no earlier than the first clk_i rising edge after deassertion.

Configuration
REQ-033 The macro BSG_FPU_DECODER_DAZ_EN SHALL control denormals-are-zero support.
REQ-034 When BSG_FPU_DECODER_DAZ_EN is defined, an input daz_i (1 bit, sampled with v_i and carried with the transaction) SHALL be added. When that sampled value is 1, denormal lanes SHALL be reported with zero_o=1, denormal_o=0, exp_o=0, man_o={1'b1,{m_p{0}}}.
REQ-035 When BSG_FPU_DECODER_DAZ_EN is not defined, there SHALL be no daz_i port, and denormals SHALL be normalized per REQ-022.

Structure
REQ-036 A shared package bsg_fpu_pkg SHALL hold the per-lane class-flags struct and the helper function for the extended exponent width.
REQ-037 Each lane SHALL instantiate one sub-module bsg_fpu_clz (width_p=m_p) for the leading-zero count.
REQ-038 The normalize shifter SHALL be inline in stage 2.

Verification (e_p=8, m_p=23, els_p=2)
REQ-039 Lane0=0x3F800000, lane1=0xFF800000, tag=5 -> after 2 cycles: v_o=1, tag_o=5; lane0 exp_o=0x07F, man_o=0x800000; lane1 infty_o=1, sign_o=1.
REQ-040 Lane0=0x00000001 -> denormal_o=1, exp_o=0x1EA (-22), man_o=0x800000; same input with daz_i=1 under DAZ_EN -> zero_o=1, exp_o=0.
REQ-041 Lane0=0x7FA00000, lane1=0x7FC00000 -> nan_o=2'b11, sig_nan_o=2'b01.
REQ-042 Accept 4 back-to-back transactions with ready_i=0 -> ready_o falls after 2 accepts, outputs held stable; then ready_i=1 -> tags drain in order at 1 per cycle with no loss.
REQ-043 Assert reset_n_i=0 asynchronously with 2 transactions in flight -> v_o=0 immediately; after release, next transaction is output with latency 2 and no stale data.
